mips_multi_ctrl: RTL and testbench
==================================

// Module: mips_multi_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath (shared ALU, single unified memory, IR/A/B/ALUOut regs).
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB; drives all datapath enables and mux selects.
//  Supports R-type (ADD/SUB/AND/OR via funct), LW, SW, BEQ, J; memory may insert wait states via mem_ready.
// PARAMETERS
//  OP_RTYPE  6'd0   R-type opcode
//  OP_LW     6'd35  load word opcode
//  OP_SW     6'd43  store word opcode
//  OP_BEQ    6'd4   branch-equal opcode
//  OP_J      6'd2   jump opcode
// PORTS
//  clk          in   1  clock; all state changes on posedge
//  rst          in   1  reset; asynchronous, active-high
//  opcode       in   6  IR[31:26]; sampled only in DECODE
//  zero         in   1  ALU zero flag; used only in BRANCH
//  mem_ready    in   1  memory access completes this cycle
//  pc_wr        out  1  PC load enable (unconditional or BEQ-taken)
//  iord         out  1  mem addr select: 0=PC, 1=ALUOut
//  mem_rd       out  1  memory read request
//  mem_wr       out  1  memory write request
//  ir_wr        out  1  IR load enable
//  reg_dst      out  1  regfile write addr: 0=rt, 1=rd
//  mem_to_reg   out  1  regfile write data: 0=ALUOut, 1=MDR
//  reg_wr       out  1  regfile write enable
//  alu_src_a    out  1  0=PC, 1=reg A
//  alu_src_b    out  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2
//  alu_op       out  2  00=add, 01=sub, 10=decode funct
//  pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target {PC[31:28],IR[25:0],2'b00}
//  instr_done   out  1  one-cycle pulse on the final cycle of each instruction
//  ill_instr    out  1  one-cycle pulse: unsupported opcode in DECODE
//  state        out  4  current state (debug/bench)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 JUMP=9; 10-15 illegal.
//  rst asserted: state=FETCH immediately; every output except state forced 0 while rst high.
//  FETCH: mem_rd, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_wr,pc_wr only when mem_ready;
//    stay in FETCH while !mem_ready (mem_rd held high); ->DECODE when mem_ready.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute); next by opcode:
//    LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, other->FETCH with ill_instr=1 (no other side effect).
//  MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; ->MEMRD if LW else MEMWR.
//  MEMRD: mem_rd, iord=1; hold until mem_ready; ->MEMWB.
//  MEMWB: reg_wr, reg_dst=0, mem_to_reg=1, instr_done; ->FETCH.
//  MEMWR: mem_wr, iord=1; hold until mem_ready; instr_done on the mem_ready cycle; ->FETCH.
//  EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; ->ALUWB.  ALUWB: reg_wr, reg_dst=1, mem_to_reg=0, instr_done; ->FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_wr=zero, instr_done; ->FETCH.
//  JUMP: pc_src=10, pc_wr=1, instr_done; ->FETCH.
//  Latency at mem_ready=1: BEQ/J 3 cycles, R-type/SW 4, LW 5; each wait cycle adds 1.
//  Unlisted outputs are 0 in each state (Moore, decoded from state; pc_wr/ir_wr/instr_done also gated as above).
//  Illegal state encoding: next state FETCH, all outputs 0.
//  mem_wr and reg_wr never both 1; mem_rd and mem_wr never both 1.
//  rst mid-instruction (any state, any wait): aborts; no write enable asserted after rst rises.
// STRUCTURE
//  Shared include mips_defs.vh: opcode/funct constants, state encodings, alu_op/alu_src_b/pc_src codes.
//  Sub-module mips_multi_ctrl_dec: combinational state(+zero,mem_ready)->control-word decoder; FSM register here.
// TESTING
//  rst=1 10ns then 0, mem_ready=1 -> state FETCH at release; mem_rd=1, ir_wr=1, pc_wr=1 first cycle.
//  opcode=0 (ADD) -> states 0,1,6,7; reg_wr=1,reg_dst=1 on cycle 4 only; instr_done once.
//  opcode=35, mem_ready low 2 cycles in MEMRD -> 0,1,2,3,3,3,4; 7 cycles; mem_rd held; reg_wr only in state 4.
//  opcode=4, zero=1 then zero=0 -> pc_wr=1 / 0 in BRANCH, pc_src=01; opcode=2 -> pc_wr=1, pc_src=10 in JUMP.
//  opcode=6'd8 -> DECODE->FETCH, ill_instr one pulse, no reg_wr/mem_wr/instr_done.
//  opcode=43, rst pulsed during MEMWR wait -> mem_wr drops immediately, state=FETCH, no instr_done.

Source files
------------

// File: rtl/mips_multi_ctrl_pkg.sv
// Shared constants, state encoding and control-word layout for the multi-cycle MIPS controller.
package mips_multi_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'd0;
    localparam logic [5:0] OpLw    = 6'd35;
    localparam logic [5:0] OpSw    = 6'd43;
    localparam logic [5:0] OpBeq   = 6'd4;
    localparam logic [5:0] OpJ     = 6'd2;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9
    } state_e;

    typedef struct packed {
        logic       pc_wr;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       ill_instr;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OpRtype) || (op == OpLw) || (op == OpSw) || (op == OpBeq) || (op == OpJ);
    endfunction

endpackage

// File: rtl/mips_multi_ctrl_if.sv
// Controller <-> datapath bundle: status inputs to the FSM and all control outputs.
interface mips_multi_ctrl_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_wr;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       ill_instr;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_wr, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
               alu_src_a, alu_src_b, alu_op, pc_src, instr_done, ill_instr, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_wr, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
               alu_src_a, alu_src_b, alu_op, pc_src, instr_done, ill_instr, state
    );

endinterface

// File: rtl/mips_multi_ctrl_dec.sv
// Moore control-word decoder; only pc_wr/ir_wr/instr_done/ill_instr look at live inputs.
module mips_multi_ctrl_dec
    import mips_multi_ctrl_pkg::*;
(
    input  state_e     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            StFetch: begin
                o_ctrl.mem_rd    = 1'b1;
                o_ctrl.alu_src_b = SrcBFour;
                o_ctrl.alu_op    = AluAdd;
                o_ctrl.pc_src    = PcAlu;
                o_ctrl.ir_wr     = i_mem_ready;
                o_ctrl.pc_wr     = i_mem_ready;
            end
            StDecode: begin
                // Branch target precomputed into ALUOut while the opcode is decoded.
                o_ctrl.alu_src_b = SrcBImmSh;
                o_ctrl.alu_op    = AluAdd;
                o_ctrl.ill_instr = ~is_supported(i_opcode);
            end
            StMemAdr: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SrcBImm;
                o_ctrl.alu_op    = AluAdd;
            end
            StMemRd: begin
                o_ctrl.mem_rd = 1'b1;
                o_ctrl.iord   = 1'b1;
            end
            StMemWb: begin
                o_ctrl.reg_wr     = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            StMemWr: begin
                o_ctrl.mem_wr     = 1'b1;
                o_ctrl.iord       = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            StExec: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SrcBReg;
                o_ctrl.alu_op    = AluFunct;
            end
            StAluWb: begin
                o_ctrl.reg_wr     = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            StBranch: begin
                o_ctrl.alu_src_a  = 1'b1;
                o_ctrl.alu_src_b  = SrcBReg;
                o_ctrl.alu_op     = AluSub;
                o_ctrl.pc_src     = PcAluOut;
                o_ctrl.pc_wr      = i_zero;
                o_ctrl.instr_done = 1'b1;
            end
            StJump: begin
                o_ctrl.pc_src     = PcJump;
                o_ctrl.pc_wr      = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Multi-cycle MIPS main control FSM: state register plus decoded, reset-gated control outputs.
module mips_multi_ctrl
    import mips_multi_ctrl_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    mips_multi_ctrl_if.master        io_ctrl
);

    state_e r_state;
    logic   r_is_lw;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StFetch;
            r_is_lw <= 1'b0;
        end else begin
            case (r_state)
                StFetch:  if (io_ctrl.mem_ready) r_state <= StDecode;
                StDecode: begin
                    // Opcode is only trusted here; remember LW vs SW for MEMADR.
                    r_is_lw <= (io_ctrl.opcode == OpLw);
                    case (io_ctrl.opcode)
                        OpLw, OpSw: r_state <= StMemAdr;
                        OpRtype:    r_state <= StExec;
                        OpBeq:      r_state <= StBranch;
                        OpJ:        r_state <= StJump;
                        default:    r_state <= StFetch;
                    endcase
                end
                StMemAdr: r_state <= r_is_lw ? StMemRd : StMemWr;
                StMemRd:  if (io_ctrl.mem_ready) r_state <= StMemWb;
                StMemWr:  if (io_ctrl.mem_ready) r_state <= StFetch;
                StExec:   r_state <= StAluWb;
                default:  r_state <= StFetch;
            endcase
        end
    end

    mips_multi_ctrl_dec u_dec (
        .i_state     (r_state),
        .i_opcode    (io_ctrl.opcode),
        .i_zero      (io_ctrl.zero),
        .i_mem_ready (io_ctrl.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign w_out = i_rst ? '0 : w_ctrl;

    assign io_ctrl.pc_wr      = w_out.pc_wr;
    assign io_ctrl.iord       = w_out.iord;
    assign io_ctrl.mem_rd     = w_out.mem_rd;
    assign io_ctrl.mem_wr     = w_out.mem_wr;
    assign io_ctrl.ir_wr      = w_out.ir_wr;
    assign io_ctrl.reg_dst    = w_out.reg_dst;
    assign io_ctrl.mem_to_reg = w_out.mem_to_reg;
    assign io_ctrl.reg_wr     = w_out.reg_wr;
    assign io_ctrl.alu_src_a  = w_out.alu_src_a;
    assign io_ctrl.alu_src_b  = w_out.alu_src_b;
    assign io_ctrl.alu_op     = w_out.alu_op;
    assign io_ctrl.pc_src     = w_out.pc_src;
    assign io_ctrl.instr_done = w_out.instr_done;
    assign io_ctrl.ill_instr  = w_out.ill_instr;
    assign io_ctrl.state      = r_state;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Directed bench for mips_multi_ctrl: one instruction of each class, wait states and mid-op reset.
module tb_mips_multi_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   done_cnt;
    int   ill_cnt;

    mips_multi_ctrl_if u_if ();

    mips_multi_ctrl u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .io_ctrl (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse counters and write-exclusivity checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (u_if.instr_done === 1'b1) done_cnt++;
        if (u_if.ill_instr === 1'b1) ill_cnt++;
        chk("excl_memwr_regwr", {3'b0, u_if.mem_wr & u_if.reg_wr}, 4'd0);
        chk("excl_memrd_memwr", {3'b0, u_if.mem_rd & u_if.mem_wr}, 4'd0);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        done_cnt = 0;
        ill_cnt = 0;
        rst = 1'b1;
        u_if.mem_ready = 1'b1;
        u_if.opcode = 6'd0;
        u_if.zero = 1'b0;

        #2;
        chk("rst_state", u_if.state, 4'd0);
        chk("rst_mem_rd", {3'b0, u_if.mem_rd}, 4'd0);
        chk("rst_pc_wr", {3'b0, u_if.pc_wr}, 4'd0);
        chk("rst_ir_wr", {3'b0, u_if.ir_wr}, 4'd0);
        #8 rst = 1'b0;
        #1;
        chk("fetch_state", u_if.state, 4'd0);
        chk("fetch_mem_rd", {3'b0, u_if.mem_rd}, 4'd1);
        chk("fetch_ir_wr", {3'b0, u_if.ir_wr}, 4'd1);
        chk("fetch_pc_wr", {3'b0, u_if.pc_wr}, 4'd1);
        chk("fetch_srcb", {2'b0, u_if.alu_src_b}, 4'd1);
        chk("fetch_iord", {3'b0, u_if.iord}, 4'd0);

        // ADD: 0,1,6,7
        step();
        chk("add_s1", u_if.state, 4'd1);
        chk("dec_srcb", {2'b0, u_if.alu_src_b}, 4'd3);
        chk("dec_ill", {3'b0, u_if.ill_instr}, 4'd0);
        step();
        chk("add_s6", u_if.state, 4'd6);
        chk("exec_aluop", {2'b0, u_if.alu_op}, 4'd2);
        chk("exec_srca", {3'b0, u_if.alu_src_a}, 4'd1);
        chk("exec_regwr", {3'b0, u_if.reg_wr}, 4'd0);
        step();
        chk("add_s7", u_if.state, 4'd7);
        chk("aluwb_regwr", {3'b0, u_if.reg_wr}, 4'd1);
        chk("aluwb_regdst", {3'b0, u_if.reg_dst}, 4'd1);
        chk("aluwb_done", {3'b0, u_if.instr_done}, 4'd1);
        step();
        chk("add_end", u_if.state, 4'd0);
        chk("add_done_cnt", done_cnt[3:0], 4'd1);

        // LW with two wait cycles: 0,1,2,3,3,3,4
        u_if.opcode = 6'd35;
        step();
        chk("lw_s1", u_if.state, 4'd1);
        step();
        chk("lw_s2", u_if.state, 4'd2);
        chk("memadr_srcb", {2'b0, u_if.alu_src_b}, 4'd2);
        u_if.mem_ready = 1'b0;
        step();
        chk("lw_s3a", u_if.state, 4'd3);
        chk("memrd_mem_rd", {3'b0, u_if.mem_rd}, 4'd1);
        chk("memrd_iord", {3'b0, u_if.iord}, 4'd1);
        step();
        chk("lw_s3b", u_if.state, 4'd3);
        chk("memrd_hold", {3'b0, u_if.mem_rd}, 4'd1);
        chk("memrd_regwr", {3'b0, u_if.reg_wr}, 4'd0);
        step();
        chk("lw_s3c", u_if.state, 4'd3);
        u_if.mem_ready = 1'b1;
        step();
        chk("lw_s4", u_if.state, 4'd4);
        chk("memwb_regwr", {3'b0, u_if.reg_wr}, 4'd1);
        chk("memwb_m2r", {3'b0, u_if.mem_to_reg}, 4'd1);
        chk("memwb_regdst", {3'b0, u_if.reg_dst}, 4'd0);
        step();
        chk("lw_end", u_if.state, 4'd0);
        chk("lw_done_cnt", done_cnt[3:0], 4'd2);

        // BEQ, taken then not taken within BRANCH
        u_if.opcode = 6'd4;
        u_if.zero = 1'b1;
        step();
        step();
        chk("beq_s8", u_if.state, 4'd8);
        chk("beq_pcwr_taken", {3'b0, u_if.pc_wr}, 4'd1);
        chk("beq_pcsrc", {2'b0, u_if.pc_src}, 4'd1);
        chk("beq_aluop", {2'b0, u_if.alu_op}, 4'd1);
        u_if.zero = 1'b0;
        #1;
        chk("beq_pcwr_nt", {3'b0, u_if.pc_wr}, 4'd0);
        step();
        chk("beq_end", u_if.state, 4'd0);
        chk("beq_done_cnt", done_cnt[3:0], 4'd3);

        // J
        u_if.opcode = 6'd2;
        step();
        step();
        chk("j_s9", u_if.state, 4'd9);
        chk("j_pcwr", {3'b0, u_if.pc_wr}, 4'd1);
        chk("j_pcsrc", {2'b0, u_if.pc_src}, 4'd2);
        step();
        chk("j_end", u_if.state, 4'd0);
        chk("j_done_cnt", done_cnt[3:0], 4'd4);

        // Unsupported opcode
        u_if.opcode = 6'd8;
        step();
        chk("ill_s1", u_if.state, 4'd1);
        chk("ill_pulse", {3'b0, u_if.ill_instr}, 4'd1);
        chk("ill_regwr", {3'b0, u_if.reg_wr}, 4'd0);
        chk("ill_memwr", {3'b0, u_if.mem_wr}, 4'd0);
        step();
        chk("ill_back", u_if.state, 4'd0);
        chk("ill_cnt", ill_cnt[3:0], 4'd1);
        chk("ill_done_cnt", done_cnt[3:0], 4'd4);

        // SW aborted by reset during its MEMWR wait
        u_if.opcode = 6'd43;
        step();
        step();
        chk("sw_s2", u_if.state, 4'd2);
        u_if.mem_ready = 1'b0;
        step();
        chk("sw_s5", u_if.state, 4'd5);
        chk("memwr_memwr", {3'b0, u_if.mem_wr}, 4'd1);
        chk("memwr_iord", {3'b0, u_if.iord}, 4'd1);
        chk("memwr_wait_done", {3'b0, u_if.instr_done}, 4'd0);
        step();
        chk("sw_s5_wait", u_if.state, 4'd5);
        rst = 1'b1;
        #1;
        chk("abort_state", u_if.state, 4'd0);
        chk("abort_memwr", {3'b0, u_if.mem_wr}, 4'd0);
        chk("abort_done", {3'b0, u_if.instr_done}, 4'd0);
        #2 rst = 1'b0;
        #1;
        chk("abort_fetch", u_if.state, 4'd0);
        chk("abort_irwr_wait", {3'b0, u_if.ir_wr}, 4'd0);
        chk("abort_memrd", {3'b0, u_if.mem_rd}, 4'd1);
        chk("abort_done_cnt", done_cnt[3:0], 4'd4);

        // SW at full speed: 0,1,2,5
        u_if.mem_ready = 1'b1;
        #1;
        chk("sw_irwr", {3'b0, u_if.ir_wr}, 4'd1);
        step();
        chk("sw2_s1", u_if.state, 4'd1);
        step();
        chk("sw2_s2", u_if.state, 4'd2);
        step();
        chk("sw2_s5", u_if.state, 4'd5);
        chk("sw2_memwr", {3'b0, u_if.mem_wr}, 4'd1);
        chk("sw2_done", {3'b0, u_if.instr_done}, 4'd1);
        step();
        chk("sw2_end", u_if.state, 4'd0);
        chk("sw2_done_cnt", done_cnt[3:0], 4'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
